// File: rtl/id_fetch_queue_pkg.sv
// Shared pipeline constants and helpers for the fetch-to-decode buffer.
//   INST_W / XLEN / REG_AW : instruction, address and register-index widths
//   sb_stage_t             : one in-flight-load scoreboard stage {v, rd}
//   slot_w / off_w         : slot-index width and block byte-offset width
package id_fetch_queue_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned XLEN   = 64;
  localparam int unsigned REG_AW = 5;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
  } sb_stage_t;

  // Slot index width; kept at least 1 bit so a single-slot block still has a port.
  function automatic int unsigned slot_w(input int unsigned fetch_w);
    return (fetch_w > INST_W) ? $clog2(fetch_w / INST_W) : 1;
  endfunction

  // Number of PC bits addressing bytes inside one fetch block.
  function automatic int unsigned off_w(input int unsigned fetch_w);
    return $clog2(fetch_w / 8);
  endfunction

endpackage

// File: rtl/load_scoreboard.sv
// In-flight load scoreboard: LOAD_LAT-stage shift register of {v, rd}
// plus the source-operand compare that raises the load-use stall.
//   advance    : pipe advances (shift one stage), else hold
//   ins_v/rd   : stage-0 content on an advance
//   rs1/rs2    : head instruction sources
//   head_valid : head instruction present
//   stall_c    : combinational load-use stall request
module load_scoreboard
  import id_fetch_queue_pkg::*;
#(
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic              ins_v,
  input  logic [REG_AW-1:0] ins_rd,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              head_valid,
  output logic              stall_c
);

  sb_stage_t [LOAD_LAT-1:0] stage_q;
  logic                     hit;

  // Shift on every advance; a non-issuing advance carries a bubble in ins_v.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else if (advance) begin
      stage_q[0] <= '{v: ins_v, rd: ins_rd};
      for (int i = 1; i < int'(LOAD_LAT); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  // Any valid stage whose rd matches a non-x0 source blocks issue.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < int'(LOAD_LAT); i++) begin
      if (stage_q[i].v &&
          (((stage_q[i].rd == rs1) && (rs1 != '0)) ||
           ((stage_q[i].rd == rs2) && (rs2 != '0)))) begin
        hit = 1'b1;
      end
    end
    stall_c = head_valid & hit;
  end

endmodule

// File: rtl/id_fetch_queue.sv
// Fetch-to-decode buffer: DEPTH-entry FIFO of fetch blocks, presenting one
// instruction per cycle with a head slot pointer, flushed on redirect, and
// gated by the in-flight-load scoreboard.
//   in_valid/in_ready/in_pc/in_data : fetch block push
//   out_valid/out_ready/out_pc/out_inst : head instruction to decode/EX
//   dec_*    : decode of out_inst fed back for hazard checking
//   issue    : head instruction leaves this cycle
//   stallreq : load-use stall request
module id_fetch_queue
  import id_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned FETCH_W  = 64,
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [FETCH_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [INST_W-1:0]  out_inst,
  input  logic [REG_AW-1:0]  dec_rs1,
  input  logic [REG_AW-1:0]  dec_rs2,
  input  logic               dec_is_load,
  input  logic               dec_rf_we,
  input  logic [REG_AW-1:0]  dec_rd,
  output logic               issue,
  output logic               stallreq
);

  localparam int unsigned SLOTS = FETCH_W / INST_W;
  localparam int unsigned SW    = slot_w(FETCH_W);
  localparam int unsigned OFFW  = off_w(FETCH_W);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [SW-1:0]   LAST_SLOT = SW'(SLOTS - 1);
  localparam logic [XLEN-1:0] BASE_MASK = ~XLEN'((1 << OFFW) - 1);

  logic [FETCH_W-1:0] data_mem [DEPTH];
  logic [XLEN-1:0]    pc_mem   [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0]   count;
  logic [SW-1:0]      slot;
  logic               push, pop, sb_ins_v;
  logic [XLEN-1:0]    head_pc, next_head_pc;

  function automatic logic [SW-1:0] start_slot(input logic [XLEN-1:0] pc);
    return SW'((pc >> 2) & XLEN'(SLOTS - 1));
  endfunction

  assign out_valid  = (count != '0);
  assign in_ready   = (count != CNT_W'(DEPTH));
  assign push       = in_valid & in_ready & ~flush;
  assign issue      = out_valid & out_ready & ~stallreq;
  assign pop        = issue & (slot == LAST_SLOT);
  assign rd_ptr_nxt = rd_ptr + PTR_W'(1);
  assign head_pc    = pc_mem[rd_ptr];

  // With one entry left, a same-cycle push becomes the next head before it lands in memory.
  assign next_head_pc = (count == CNT_W'(1)) ? in_pc : pc_mem[rd_ptr_nxt];

  // Head instruction view; zeroed while empty.
  assign out_pc   = out_valid ? ((head_pc & BASE_MASK) | (XLEN'(slot) << 2)) : '0;
  assign out_inst = out_valid ? INST_W'(data_mem[rd_ptr] >> {slot, 5'd0}) : '0;

  // Block storage; contents are only observed through valid entries.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= in_data;
      pc_mem[wr_ptr]   <= in_pc;
    end
  end

  // Pointers, occupancy and head slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      slot   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      slot   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr_nxt;
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (pop)                        slot <= start_slot(next_head_pc);
      else if (issue)                 slot <= slot + SW'(1);
      else if (push && count == '0)   slot <= start_slot(in_pc);
    end
  end

  // Only loads that write a real register occupy a scoreboard stage.
  assign sb_ins_v = issue & dec_is_load & dec_rf_we & (dec_rd != '0);

  load_scoreboard #(
    .LOAD_LAT (LOAD_LAT)
  ) u_load_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .advance    (out_ready),
    .ins_v      (sb_ins_v),
    .ins_rd     (dec_rd),
    .rs1        (dec_rs1),
    .rs2        (dec_rs2),
    .head_valid (out_valid),
    .stall_c    (stallreq)
  );

endmodule

// File: tb/tb_id_fetch_queue.sv
// Bench for id_fetch_queue: directed scenarios plus randomized traffic,
// checked against a queue-of-instructions model with a pending-load list.
// A second instance with LOAD_LAT=2 covers the longer stall window.
module tb_id_fetch_queue;
  import id_fetch_queue_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned FETCH_W = 64;
  localparam int          LAT     = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               flush, in_valid, in_ready, out_valid, out_ready, issue, stallreq;
  logic [63:0]        in_pc, out_pc;
  logic [FETCH_W-1:0] in_data;
  logic [31:0]        out_inst;
  logic [4:0]         dec_rs1, dec_rs2, dec_rd;
  logic               dec_is_load, dec_rf_we;

  logic               b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_issue, b_stallreq;
  logic [63:0]        b_in_pc, b_out_pc;
  logic [FETCH_W-1:0] b_in_data;
  logic [31:0]        b_out_inst;
  logic [4:0]         b_dec_rs1, b_dec_rs2, b_dec_rd;
  logic               b_dec_is_load, b_dec_rf_we;

  // Toy decoder: bit 31 marks a no-writeback variant so the rf_we gate matters.
  function automatic logic [4:0] f_rs1(input logic [31:0] i); return i[19:15]; endfunction
  function automatic logic [4:0] f_rs2(input logic [31:0] i); return i[24:20]; endfunction
  function automatic logic [4:0] f_rd (input logic [31:0] i); return i[11:7];  endfunction
  function automatic logic f_load(input logic [31:0] i); return i[6:0] == 7'b0000011; endfunction
  function automatic logic f_we(input logic [31:0] i);
    return (i[6:0] != 7'b0100011) && !i[31];
  endfunction

  assign dec_rs1     = f_rs1(out_inst);
  assign dec_rs2     = f_rs2(out_inst);
  assign dec_rd      = f_rd(out_inst);
  assign dec_is_load = f_load(out_inst);
  assign dec_rf_we   = f_we(out_inst);

  assign b_dec_rs1     = f_rs1(b_out_inst);
  assign b_dec_rs2     = f_rs2(b_out_inst);
  assign b_dec_rd      = f_rd(b_out_inst);
  assign b_dec_is_load = f_load(b_out_inst);
  assign b_dec_rf_we   = f_we(b_out_inst);

  id_fetch_queue #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .LOAD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_is_load(dec_is_load), .dec_rf_we(dec_rf_we), .dec_rd(dec_rd),
    .issue(issue), .stallreq(stallreq)
  );

  id_fetch_queue #(.DEPTH(4), .FETCH_W(64), .LOAD_LAT(2)) dut_l2 (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_pc(b_in_pc), .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_pc(b_out_pc), .out_inst(b_out_inst), .dec_rs1(b_dec_rs1), .dec_rs2(b_dec_rs2),
    .dec_is_load(b_dec_is_load), .dec_rf_we(b_dec_rf_we), .dec_rd(b_dec_rd),
    .issue(b_issue), .stallreq(b_stallreq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model: flat instruction queue, per-block remaining counts,
  // and loads with the number of advances they stay unforwardable.
  typedef struct { logic [63:0] pc; logic [31:0] inst; } ins_t;
  typedef struct { int cnt; logic [4:0] rd; } ld_t;

  ins_t iq[$];
  int   blk_len[$];
  ld_t  pl[$];
  logic exp_issue_m;

  task automatic model_reset();
    iq.delete();
    blk_len.delete();
    pl.delete();
  endtask

  task automatic model_check(input logic ordy);
    logic        ev, est, eis;
    logic [63:0] epc;
    logic [31:0] ein;
    logic [4:0]  r1, r2;
    ev  = iq.size() > 0;
    epc = ev ? iq[0].pc : 64'h0;
    ein = ev ? iq[0].inst : 32'h0;
    r1  = f_rs1(ein);
    r2  = f_rs2(ein);
    est = 1'b0;
    if (ev) begin
      foreach (pl[j]) begin
        if ((pl[j].rd == r1 && r1 != 0) || (pl[j].rd == r2 && r2 != 0)) est = 1'b1;
      end
    end
    eis = ev & ordy & ~est;
    check_eq("in_ready",  64'(in_ready),  64'(blk_len.size() < DEPTH));
    check_eq("out_valid", 64'(out_valid), 64'(ev));
    check_eq("out_pc",    out_pc,         epc);
    check_eq("out_inst",  64'(out_inst),  64'(ein));
    check_eq("stallreq",  64'(stallreq),  64'(est));
    check_eq("issue",     64'(issue),     64'(eis));
    exp_issue_m = eis;
  endtask

  task automatic model_step(input logic iv, input logic [63:0] pc, input logic [63:0] data,
                            input logic ordy, input logic fl);
    logic rdy;
    int   st;
    rdy = blk_len.size() < DEPTH;
    if (ordy) begin
      foreach (pl[j]) pl[j].cnt--;
      while (pl.size() > 0 && pl[0].cnt == 0) void'(pl.pop_front());
      if (exp_issue_m && f_load(iq[0].inst) && f_we(iq[0].inst) && f_rd(iq[0].inst) != 0)
        pl.push_back('{cnt: LAT, rd: f_rd(iq[0].inst)});
    end
    if (exp_issue_m) begin
      void'(iq.pop_front());
      blk_len[0]--;
      if (blk_len[0] == 0) void'(blk_len.pop_front());
    end
    if (fl) begin
      iq.delete();
      blk_len.delete();
    end else if (iv && rdy) begin
      st = int'(pc[2]);
      for (int s = st; s < 2; s++) iq.push_back('{pc: pc + 64'(4 * (s - st)), inst: data[32*s +: 32]});
      blk_len.push_back(2 - st);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, compare, then advance the model.
  task automatic cycle(input logic iv, input logic [63:0] pc, input logic [63:0] data,
                       input logic ordy, input logic fl);
    @(negedge clk);
    in_valid  = iv;
    in_pc     = pc;
    in_data   = data;
    out_ready = ordy;
    flush     = fl;
    #1;
    model_check(ordy);
    model_step(iv, pc, data, ordy, fl);
  endtask

  function automatic logic [31:0] gen_inst();
    logic [6:0] op;
    int         k;
    k  = $urandom_range(0, 2);
    op = (k == 0) ? 7'b0000011 : (k == 1) ? 7'b0010011 : 7'b0100011;
    return {1'($urandom_range(0, 3) == 0), 6'($urandom), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 3'b010, 5'($urandom_range(0, 3)), op};
  endfunction

  task automatic drain();
    for (int k = 0; k < 60 && iq.size() > 0; k++) cycle(1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
  endtask

  localparam logic [63:0] D_ADDI = 64'h00200093_00100093;
  localparam logic [63:0] D_LDU  = 64'h00028093_00002283;
  localparam logic [63:0] D_LD0  = 64'h00100093_00002283;

  logic l2_st [4];
  logic l2_is [4];

  initial begin
    l2_st = '{1'b0, 1'b1, 1'b1, 1'b0};
    l2_is = '{1'b1, 1'b0, 1'b0, 1'b1};
    rst_n = 1'b0;
    {flush, in_valid, out_ready} = '0;
    in_pc = '0; in_data = '0;
    {b_flush, b_in_valid, b_out_ready} = '0;
    b_in_pc = '0; b_in_data = '0;
    exp_issue_m = 1'b0;

    #2;
    model_check(1'b0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Slot extraction from an aligned block.
    cycle(1'b1, 64'h1000, D_ADDI, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
    check_eq("slot0_inst", 64'(out_inst), 64'h00100093);
    check_eq("slot0_pc", out_pc, 64'h1000);
    cycle(1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
    check_eq("slot1_inst", 64'(out_inst), 64'h00200093);
    check_eq("slot1_pc", out_pc, 64'h1004);
    cycle(1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
    check_eq("drained_valid", 64'(out_valid), 64'd0);

    // Unaligned start: only the upper slot is delivered.
    cycle(1'b1, 64'h1004, D_ADDI, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
    check_eq("unal_inst", 64'(out_inst), 64'h00200093);
    check_eq("unal_pc", out_pc, 64'h1004);
    check_eq("unal_issue", 64'(issue), 64'd1);
    cycle(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    check_eq("unal_popped", 64'(out_valid), 64'd0);

    // Load-use stall, including hold while out_ready is low.
    cycle(1'b1, 64'h2000, D_LDU, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
    check_eq("ld_issue", 64'(issue), 64'd1);
    cycle(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    check_eq("stall_hold_a", 64'(stallreq), 64'd1);
    cycle(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    check_eq("stall_hold_b", 64'(stallreq), 64'd1);
    cycle(1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
    check_eq("stall_adv", 64'(stallreq), 64'd1);
    check_eq("stall_noissue", 64'(issue), 64'd0);
    cycle(1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
    check_eq("stall_clear", 64'(stallreq), 64'd0);
    check_eq("dep_issue", 64'(issue), 64'd1);
    cycle(1'b1, 64'h2008, D_LD0, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
    cycle(1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
    check_eq("x0_nostall", 64'(stallreq), 64'd0);
    check_eq("x0_issue", 64'(issue), 64'd1);

    // Backpressure: five pushes into a stalled queue of depth 4.
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 64'h3000 + 64'(8 * k), {gen_inst(), gen_inst()}, 1'b0, 1'b0);
      check_eq("bp_in_ready", 64'(in_ready), 64'(k < 4));
    end
    drain();

    // Flush with a concurrent push and an issuing load.
    cycle(1'b1, 64'h5000, 64'h00000013_00002283, 1'b0, 1'b0);
    cycle(1'b1, 64'h5008, {gen_inst(), gen_inst()}, 1'b0, 1'b0);
    cycle(1'b1, 64'h5010, {gen_inst(), gen_inst()}, 1'b0, 1'b0);
    cycle(1'b1, 64'h6000, D_ADDI, 1'b1, 1'b1);
    check_eq("flush_issue", 64'(issue), 64'd1);
    cycle(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    check_eq("flush_valid", 64'(out_valid), 64'd0);
    check_eq("flush_in_ready", 64'(in_ready), 64'd1);
    cycle(1'b1, 64'h7000, 64'h00000013_00028093, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    check_eq("postflush_stall", 64'(stallreq), 64'd1);
    check_eq("postflush_pc", out_pc, 64'h7000);
    cycle(1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
    check_eq("postflush_noissue", 64'(issue), 64'd0);
    cycle(1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
    check_eq("postflush_issue", 64'(issue), 64'd1);
    drain();

    // Randomized traffic with phases of heavy backpressure.
    for (int n = 0; n < 1500; n++) begin
      logic        iv, ordy, fl;
      logic [63:0] pc;
      iv   = $urandom_range(0, 9) < 6;
      ordy = ((n % 200) < 40) ? ($urandom_range(0, 9) < 1) : ($urandom_range(0, 9) < 7);
      fl   = $urandom_range(0, 49) == 0;
      pc   = {32'h0, 16'h0, 13'($urandom), 1'($urandom), 2'b00};
      cycle(iv, pc, {gen_inst(), gen_inst()}, ordy, fl);
    end
    drain();

    // Asynchronous reset while full with a stall pending.
    cycle(1'b1, 64'h4000, D_LDU, 1'b0, 1'b0);
    for (int k = 1; k < 4; k++) cycle(1'b1, 64'h4000 + 64'(8 * k), {gen_inst(), gen_inst()}, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
    check_eq("ar_ld_issue", 64'(issue), 64'd1);
    cycle(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    check_eq("ar_pre_stall", 64'(stallreq), 64'd1);
    check_eq("ar_pre_full", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_valid", 64'(out_valid), 64'd0);
    check_eq("ar_stall", 64'(stallreq), 64'd0);
    check_eq("ar_in_ready", 64'(in_ready), 64'd1);
    check_eq("ar_out_pc", out_pc, 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // LOAD_LAT=2 instance: a dependent instruction waits two advances.
    @(negedge clk);
    b_in_valid  = 1'b1;
    b_in_pc     = 64'h2000;
    b_in_data   = D_LDU;
    b_out_ready = 1'b1;
    #1;
    check_eq("l2_empty", 64'(b_out_valid), 64'd0);
    @(negedge clk);
    b_in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check_eq("l2_stall", 64'(b_stallreq), 64'(l2_st[k]));
      check_eq("l2_issue", 64'(b_issue), 64'(l2_is[k]));
    end
    check_eq("l2_dep_inst", 64'(b_out_inst), 64'h00028093);
    @(negedge clk);
    #1;
    check_eq("l2_done", 64'(b_out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_fetch_queue.md
# id_fetch_queue

Parametrised fetch-to-decode buffer for the RV64 pipeline. It accepts aligned fetch blocks of `FETCH_W` bits, each holding `FETCH_W/32` instructions, and queues them in a `DEPTH`-entry FIFO. It presents one 32-bit instruction per cycle to the decoder and cancels queued instructions on a branch flush. It also generalises load-use hazard detection to a `LOAD_LAT`-deep in-flight-load scoreboard, and gates issue with it.

## Interface
Parameters:
- `DEPTH`, 4, number of fetch-block entries; power of two, ≥2.
- `FETCH_W`, 64, fetch block width in bits; power of two, 32..256.
- `LOAD_LAT`, 1, pipeline advances after issue during which a load result is not forwardable; 1..4.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low, as already decided.
- `flush`  in  1  branch redirect; empties the queue.
- `in_valid`  in  1  fetch block valid.
- `in_ready`  out  1  queue not full.
- `in_pc`  in  64  PC of the first wanted instruction; bits [1:0] are 0.
- `in_data`  in  `FETCH_W`  fetch block; slot k is bits [32k+31:32k].
- `out_valid`  out  1  head instruction valid.
- `out_ready`  in  1  downstream (EX) advances this cycle; doubles as the pipe-advance signal.
- `out_pc`  out  64  head instruction PC.
- `out_inst`  out  32  head instruction.
- `dec_rs1`, `dec_rs2`  in  5  source registers decoded from `out_inst`.
- `dec_is_load`, `dec_rf_we`  in  1  head instruction is a load / writes the register file.
- `dec_rd`  in  5  destination register.
- `issue`  out  1  `out_valid & out_ready & ~stallreq`.
- `stallreq`  out  1  load-use stall request, consumed by the stall controller.

## Operation
- Constant: `SLOTS = FETCH_W/32`, `OFFW = log2(FETCH_W/8)`.
- Each entry stores {block, base_pc}. The head keeps a slot pointer, initialised to `in_pc[OFFW-1:2]` at push time.
- Push: `in_valid & in_ready & ~flush` writes the entry at the tail.
- Output: `out_pc = {base_pc[63:OFFW], slot, 2'b00}`; `out_inst` is the slot of the head block.
  - When `out_valid=0`, `out_pc` and `out_inst` read 0.
- On `issue`, the slot increments.
  - If the slot was `SLOTS-1`, the entry pops and the next entry starts at its own stored start slot.
- Scoreboard: a shift register of `LOAD_LAT` stages holding {v, rd}.
  - On each `out_ready` cycle it shifts by one.
  - Stage 0 loads {`issue & dec_is_load & dec_rf_we & dec_rd!=0`, `dec_rd`}; any non-issuing advance inserts a bubble (v=0).
  - When `out_ready=0` it holds.
- `stallreq = out_valid & OR over valid stages of ((rd==dec_rs1 & dec_rs1!=0) | (rd==dec_rs2 & dec_rs2!=0))`.
- `flush` empties the FIFO, resets the pointers and drops any same-cycle push. It does not clear the scoreboard, because loads older than the branch are still in flight.

## Timing
- Reset values: pointers, count, slot and scoreboard all 0. Outputs: `in_ready=1`, `out_valid=0`, `out_pc=0`, `out_inst=0`, `issue=0`, `stallreq=0`.
- Latency: a pushed block is visible at the output the cycle after the push edge. There is no input-to-output bypass.
- Full: `in_ready=0` when count==`DEPTH`. A pop in that cycle does not raise `in_ready` until the next cycle.
- Empty: `out_valid=0`, and `issue` is suppressed.
- Simultaneous push and pop with the queue not full: count is unchanged.
- Flush in the same cycle as an issue: the issue is recorded in the scoreboard and the queue is emptied. In the next cycle `out_valid=0`.
- Reset asserted mid-operation: all state clears immediately (asynchronously). Outputs return to their reset values before the next edge.
- Pointer wrap-around is modulo `DEPTH`; count is `log2(DEPTH)+1` bits wide.

## Structure
- The shared pipeline package holds `INST_W=32`, `XLEN=64`, `REG_AW=5`, and the slot/offset width function.
- The natural sub-module is `load_scoreboard`: the `LOAD_LAT` shift register plus the compare logic.
- The FIFO and slot extraction stay in `id_fetch_queue`.

## Test plan
- **Slot extraction.** Setup: `FETCH_W=64`; push pc=0x1000 with data {0x00200093, 0x00100093}. Required response: output 0x00100093 @0x1000, then 0x00200093 @0x1004, then `out_valid=0`.
- **Unaligned start.** Push pc=0x1004 with the same data. Required response: a single output 0x00200093 @0x1004, and the entry pops after one issue.
- **Load-use stall.** Issue a load to x5 with `LOAD_LAT=1`; the next head has rs1=5. Required response: `stallreq=1` for one `out_ready` cycle, then the instruction issues. With rs1=0 there is no stall. With `LOAD_LAT=2` the stall lasts 2 advances.
- **Backpressure.** Hold `out_ready=0` with `DEPTH=4` and push 5 blocks. Required response: `in_ready` falls after 4; the scoreboard holds; order is preserved after release.
- **Flush.** Flush with 3 entries queued while a push arrives. Required response: next cycle `out_valid=0` and count 0; the pushed block is dropped; a pending load still stalls the first post-flush dependent instruction.
- **Async reset.** Assert `rst_n=0` between edges while the queue is full. Required response: `out_valid`, `stallreq` and `in_ready` take their reset values immediately.
